rv32i_mem_stage: RTL and testbench
==================================

RV32I_MEM_STAGE -- requirements
Module: rv32i_mem_stage
Interface (block SHALL provide, in this order):
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles waited for dmem_ack before abort.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 valid_in  input  1  EX-stage slot holds an instruction.
REQ-005 alu_in  input  32  EX result; effective address for loads/stores.
REQ-006 iw_in  input  32  instruction word; opcode iw[6:0], func3 iw[14:12].
REQ-007 pc_in  input  32  instruction PC.
REQ-008 rs2_data_in  input  32  store data.
REQ-009 wb_en_in  input  1  writeback requested.
REQ-010 wb_reg_in  input  5  destination register.
REQ-011 stall_out  output  1  upstream SHALL hold inputs while high.
REQ-012 dmem_req  output  1  data-memory access request.
REQ-013 dmem_we  output  1  1 = write, 0 = read.
REQ-014 dmem_addr  output  30  word address (alu[31:2]).
REQ-015 dmem_be  output  4  byte enables.
REQ-016 dmem_wdata  output  32  lane-replicated store data.
REQ-017 dmem_rdata  input  32  read data, valid with dmem_ack.
REQ-018 dmem_ack  input  1  access complete, one-cycle pulse.
REQ-019 valid_out  output  1  one-cycle pulse per retired instruction.
REQ-020 wb_data_out  output  32  writeback value.
REQ-021 wb_en_out  output  1  writeback enable.
REQ-022 wb_reg_out  output  5  destination register.
REQ-023 iw_out / pc_out  output  32 each  instruction word / PC, passed through.
REQ-024 fault_out  output  2  01 misaligned, 10 timeout, 00 none; valid with valid_out.
Function:
- REQ-025 Accept = valid_in & ~stall_out at a rising edge; stall_out = (state != IDLE).
- REQ-026 FSM states IDLE, ACCESS; IDLE->ACCESS on accepting an aligned load/store (opcode 0000011/0100011, legal func3); ACCESS->IDLE on dmem_ack or timeout.
- REQ-027 Non-memory op: outputs registered at accept edge, valid_out high next cycle (latency 1), wb_data_out = alu_in.
- REQ-028 dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata driven from registers, held constant while in ACCESS; dmem_req = (state == ACCESS).
- REQ-029 On dmem_ack in ACCESS: results registered that edge, valid_out next cycle; ack in same cycle as first req gives latency 2.
- REQ-030 Loads: LB/LBU byte at alu[1:0], LH/LHU half at alu[1], LW word; LB/LH sign-extend, LBU/LHU zero-extend.
- REQ-031 Stores: SB be = 0001<<alu[1:0], wdata = 4x rs2[7:0]; SH be = 0011<<alu[1:0] (alu[1:0] in {0,2}), wdata = 2x rs2[15:0]; SW be = 1111, wdata = rs2.
- REQ-032 Stores and illegal load/store func3 SHALL force wb_en_out = 0; illegal func3 retires in 1 cycle, no access.
- REQ-033 Misaligned (half with alu[0]=1, word with alu[1:0]!=0): no access, 1-cycle retire, fault_out = 01, wb_en_out = 0.
- REQ-034 Wait counter starts at 0 on entering ACCESS; after ACK_TIMEOUT cycles without ack: dmem_req drops, retire with fault_out = 10, wb_en_out = 0.
- REQ-035 wb_reg_out = 0 SHALL force wb_en_out = 0.
- REQ-036 dmem_ack while IDLE SHALL be ignored.
Reset:
- REQ-037 Reset: state IDLE, counter 0, every output 0 (incl. dmem_req, stall_out, valid_out); outstanding access abandoned, dmem_req low the cycle after reset is sampled.
- REQ-038 Reset overrides simultaneous accept or ack; no valid_out for the abandoned instruction.
Structure:
- REQ-039 Package rv32i_pkg SHALL hold opcode and func3 constants, fault codes, FSM state enum.
- REQ-040 Sub-module rv32i_load_align SHALL do combinational byte/half extraction and sign/zero extension.
Verification:
- REQ-041 ADD, alu_in=0x0000_0042, wb_reg 5 -> next cycle valid_out=1, wb_data_out=0x42, wb_en_out=1, no dmem_req.
- REQ-042 LB at 0x103, rdata=0x80FF_1234, ack after 3 cycles -> stall 3+ cycles, wb_data_out=0xFFFF_FF80.
- REQ-043 SH at 0x202, rs2=0xAAAA_BEEF -> dmem_we=1, addr=0x80, be=1100, wdata=0xBEEF_BEEF, wb_en_out=0.
- REQ-044 LW at 0x101 -> no dmem_req, fault_out=01, wb_en_out=0, valid_out 1 cycle later.
- REQ-045 LW, no ack for 15 cycles -> dmem_req drops, fault_out=10; late ack ignored.
- REQ-046 Reset asserted mid-ACCESS -> dmem_req=0 next cycle, no valid_out, next ADD accepted normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I memory stage: opcodes, func3 encodings,
// fault codes and the access FSM state type.
package rv32i_pkg;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [1:0] {
    FaultNone     = 2'b00,
    FaultMisalign = 2'b01,
    FaultTimeout  = 2'b10
  } fault_e;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

  function automatic logic func3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3Byte, F3Half, F3Word};
    return f3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU};
  endfunction

endpackage

// File: rtl/rv32i_mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface rv32i_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/rv32i_load_align.sv
// Selects the addressed byte/half/word from a read word and sign/zero-extends it.
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (func3_i)
      F3Byte:  data_o = {{24{byte_v[7]}}, byte_v};
      F3Half:  data_o = {{16{half_v[15]}}, half_v};
      F3ByteU: data_o = {24'd0, byte_v};
      F3HalfU: data_o = {16'd0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: passes non-memory ops through in one cycle and runs
// loads/stores on the data-memory bus with an ack timeout.
module rv32i_mem_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [31:0]               alu_in,
  input  logic [31:0]               iw_in,
  input  logic [31:0]               pc_in,
  input  logic [31:0]               rs2_data_in,
  input  logic                      wb_en_in,
  input  logic [4:0]                wb_reg_in,
  output logic                      stall_out,
  rv32i_mem_stage_if.master         dmem,
  output logic                      valid_out,
  output logic [31:0]               wb_data_out,
  output logic                      wb_en_out,
  output logic [4:0]                wb_reg_out,
  output logic [31:0]               iw_out,
  output logic [31:0]               pc_out,
  output logic [1:0]                fault_out
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [29:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     pend_iw_q, pend_iw_d, pend_pc_q, pend_pc_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic            pend_wb_q, pend_wb_d;
  logic [2:0]      pend_f3_q, pend_f3_d;
  logic [1:0]      pend_lo_q, pend_lo_d;
  logic            valid_q, valid_d, wb_en_q, wb_en_d;
  logic [31:0]     wb_data_q, wb_data_d, iw_q, iw_d, pc_q, pc_d;
  logic [4:0]      wb_reg_q, wb_reg_d;
  fault_e          fault_q, fault_d;

  logic        is_load, is_store, legal, misaligned, wb_ok;
  logic [2:0]  f3;
  logic [31:0] ld_data;

  rv32i_load_align u_load_align (
    .rdata_i   (dmem.dmem_rdata),
    .func3_i   (pend_f3_q),
    .addr_lo_i (pend_lo_q),
    .data_o    (ld_data)
  );

  always_comb begin
    f3         = iw_in[14:12];
    is_load    = iw_in[6:0] == OpLoad;
    is_store   = iw_in[6:0] == OpStore;
    legal      = func3_legal(is_store, f3);
    misaligned = (f3[1:0] == 2'b01 && alu_in[0]) || (f3[1:0] == 2'b10 && alu_in[1:0] != 2'b00);
    wb_ok      = wb_en_in && (wb_reg_in != 5'd0);

    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    pend_iw_d = pend_iw_q;
    pend_pc_d = pend_pc_q;
    pend_rd_d = pend_rd_q;
    pend_wb_d = pend_wb_q;
    pend_f3_d = pend_f3_q;
    pend_lo_d = pend_lo_q;
    valid_d   = 1'b0;
    wb_en_d   = wb_en_q;
    wb_data_d = wb_data_q;
    wb_reg_d  = wb_reg_q;
    iw_d      = iw_q;
    pc_d      = pc_q;
    fault_d   = fault_q;

    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          if (is_load || is_store) begin
            pend_iw_d = iw_in;
            pend_pc_d = pc_in;
            pend_rd_d = wb_reg_in;
            pend_wb_d = is_load && wb_ok;
            pend_f3_d = f3;
            pend_lo_d = alu_in[1:0];
          end
          if ((is_load || is_store) && legal && !misaligned) begin
            state_d = StAccess;
            cnt_d   = '0;
            we_d    = is_store;
            addr_d  = alu_in[31:2];
            case (f3[1:0])
              2'b00:   begin be_d = 4'b0001 << alu_in[1:0]; wdata_d = {4{rs2_data_in[7:0]}};  end
              2'b01:   begin be_d = 4'b0011 << alu_in[1:0]; wdata_d = {2{rs2_data_in[15:0]}}; end
              default: begin be_d = 4'b1111;                wdata_d = rs2_data_in;           end
            endcase
            if (!is_store) begin
              be_d    = 4'b1111;
              wdata_d = '0;
            end
          end else begin
            // Retires at the accept edge: non-memory op, illegal func3 or misaligned.
            valid_d   = 1'b1;
            wb_data_d = alu_in;
            wb_reg_d  = wb_reg_in;
            iw_d      = iw_in;
            pc_d      = pc_in;
            wb_en_d   = (is_load || is_store) ? 1'b0 : wb_ok;
            fault_d   = ((is_load || is_store) && legal) ? FaultMisalign : FaultNone;
          end
        end
      end
      StAccess: begin
        if (dmem.dmem_ack || cnt_q == CntMax) begin
          state_d   = StIdle;
          valid_d   = 1'b1;
          wb_reg_d  = pend_rd_q;
          iw_d      = pend_iw_q;
          pc_d      = pend_pc_q;
          if (dmem.dmem_ack) begin
            wb_data_d = ld_data;
            wb_en_d   = pend_wb_q;
            fault_d   = FaultNone;
          end else begin
            wb_data_d = {addr_q, pend_lo_q};
            wb_en_d   = 1'b0;
            fault_d   = FaultTimeout;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      pend_iw_q <= '0;
      pend_pc_q <= '0;
      pend_rd_q <= '0;
      pend_wb_q <= 1'b0;
      pend_f3_q <= '0;
      pend_lo_q <= '0;
      valid_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      wb_reg_q  <= '0;
      iw_q      <= '0;
      pc_q      <= '0;
      fault_q   <= FaultNone;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      pend_iw_q <= pend_iw_d;
      pend_pc_q <= pend_pc_d;
      pend_rd_q <= pend_rd_d;
      pend_wb_q <= pend_wb_d;
      pend_f3_q <= pend_f3_d;
      pend_lo_q <= pend_lo_d;
      valid_q   <= valid_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
      wb_reg_q  <= wb_reg_d;
      iw_q      <= iw_d;
      pc_q      <= pc_d;
      fault_q   <= fault_d;
    end
  end

  assign stall_out       = state_q != StIdle;
  assign dmem.dmem_req   = state_q == StAccess;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign valid_out       = valid_q;
  assign wb_data_out     = wb_data_q;
  assign wb_en_out       = wb_en_q;
  assign wb_reg_out      = wb_reg_q;
  assign iw_out          = iw_q;
  assign pc_out          = pc_q;
  assign fault_out       = fault_q;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Scoreboard bench for rv32i_mem_stage: directed cases then randomized traffic
// against a reference model with its own copy of data memory.
module tb_rv32i_mem_stage;
  import rv32i_pkg::*;

  localparam int unsigned TO = 15;
  localparam logic [6:0] OpAdd  = 7'b0110011;
  localparam logic [6:0] OpAddi = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] alu_in = '0, iw_in = '0, pc_in = '0, rs2_data_in = '0;
  logic        wb_en_in = 1'b0;
  logic [4:0]  wb_reg_in = '0;
  logic        stall_out, valid_out, wb_en_out;
  logic [31:0] wb_data_out, iw_out, pc_out;
  logic [4:0]  wb_reg_out;
  logic [1:0]  fault_out;

  always #5 clk = ~clk;

  rv32i_mem_stage_if bus ();

  rv32i_mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .alu_in      (alu_in),
    .iw_in       (iw_in),
    .pc_in       (pc_in),
    .rs2_data_in (rs2_data_in),
    .wb_en_in    (wb_en_in),
    .wb_reg_in   (wb_reg_in),
    .stall_out   (stall_out),
    .dmem        (bus),
    .valid_out   (valid_out),
    .wb_data_out (wb_data_out),
    .wb_en_out   (wb_en_out),
    .wb_reg_out  (wb_reg_out),
    .iw_out      (iw_out),
    .pc_out      (pc_out),
    .fault_out   (fault_out)
  );

  typedef struct {
    logic [31:0] iw, pc, data;
    bit          chk_data;
    logic        wb_en;
    logic [4:0]  rd;
    logic [1:0]  fault;
  } ret_t;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
  } bus_t;

  ret_t        ret_q[$];
  bus_t        bus_q[$];
  logic [31:0] model_mem[1024];
  logic [31:0] bus_mem[1024];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Reference model: computes the retire record and bus access at issue time.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic wen, input logic [4:0] rd,
                       input int delay, input bit expect_ret);
    logic [31:0] iw, pc, word, v;
    ret_t        r;
    bus_t        b;
    bit          st, legal;
    int          sz, lo, n;
    iw = $urandom;
    iw[6:0] = op;
    iw[14:12] = f3;
    pc = $urandom & 32'hffff_fffc;
    r.iw = iw; r.pc = pc; r.rd = rd; r.data = alu; r.chk_data = 1;
    r.fault = FaultNone;
    r.wb_en = wen && (rd != 0);
    if (op == OpLoad || op == OpStore) begin
      st    = (op == OpStore);
      legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
      sz    = int'(f3) % 4;
      lo    = int'(alu % 4);
      r.wb_en = 0;
      r.chk_data = 0;
      if (legal) begin
        if ((sz == 1 && alu % 2 != 0) || (sz == 2 && lo != 0)) begin
          r.fault = FaultMisalign;
        end else begin
          b.we = st; b.addr = alu[31:2]; b.delay = delay;
          if (st) begin
            b.be    = (sz == 0) ? 4'(1 << lo) : (sz == 1) ? 4'(3 << lo) : 4'hf;
            b.wdata = (sz == 0) ? rs2[7:0] * 32'h0101_0101 :
                      (sz == 1) ? rs2[15:0] * 32'h0001_0001 : rs2;
          end else begin
            b.be = 4'hf;
            b.wdata = '0;
          end
          bus_q.push_back(b);
          if (delay >= int'(TO)) begin
            r.fault = FaultTimeout;
          end else if (st) begin
            model_mem[alu[11:2]] = merge(model_mem[alu[11:2]], b.wdata, b.be);
          end else begin
            word = model_mem[alu[11:2]];
            if (sz == 2) v = word;
            else if (sz == 1) begin
              v = (word >> (8 * lo)) & 32'hffff;
              if (f3 == F3Half && v[15]) v = v | 32'hffff_0000;
            end else begin
              v = (word >> (8 * lo)) & 32'hff;
              if (f3 == F3Byte && v[7]) v = v | 32'hffff_ff00;
            end
            r.data = v;
            r.chk_data = 1;
            r.wb_en = wen && (rd != 0);
          end
        end
      end
    end
    if (expect_ret) ret_q.push_back(r);
    valid_in = 1'b1; iw_in = iw; pc_in = pc; alu_in = alu; rs2_data_in = rs2;
    wb_en_in = wen; wb_reg_in = rd;
    n = 0;
    @(negedge clk);
    while (stall_out) begin
      n++;
      if (n > 100) begin
        $display("FAIL issue: stall_out stuck high, got 1 expected 0");
        $fatal(1, "stall timeout");
      end
      @(negedge clk);
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!valid_out && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(valid_out), 32'd1);
  endtask

  // Memory responder: compares each access with the model's expectation.
  initial begin : responder
    bus_t e;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      tick();
      if (bus.dmem_req && !reset) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus.unexpected: got req=1 expected req=0");
          e.delay = 0;
        end else begin
          e = bus_q.pop_front();
          chk("bus.we", 32'(bus.dmem_we), 32'(e.we));
          chk("bus.addr", 32'(bus.dmem_addr), 32'(e.addr));
          if (e.we) begin
            chk("bus.be", 32'(bus.dmem_be), 32'(e.be));
            chk("bus.wdata", bus.dmem_wdata, e.wdata);
          end
        end
        repeat (e.delay) tick();
        if (bus.dmem_req && bus.dmem_we)
          bus_mem[bus.dmem_addr[9:0]] = merge(bus_mem[bus.dmem_addr[9:0]], bus.dmem_wdata,
                                              bus.dmem_be);
        bus.dmem_rdata = bus_mem[bus.dmem_addr[9:0]];
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = $urandom;
      end
    end
  end

  initial begin : monitor
    ret_t r;
    forever begin
      @(negedge clk);
      if (!reset && valid_out) begin
        if (ret_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ret.unexpected: got valid_out=1 expected 0");
        end else begin
          r = ret_q.pop_front();
          chk("ret.iw", iw_out, r.iw);
          chk("ret.pc", pc_out, r.pc);
          chk("ret.rd", 32'(wb_reg_out), 32'(r.rd));
          chk("ret.wb_en", 32'(wb_en_out), 32'(r.wb_en));
          chk("ret.fault", 32'(fault_out), 32'(r.fault));
          if (r.chk_data) chk("ret.data", wb_data_out, r.data);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu;
    int          kind, delay, n, stall_cnt;
    int          delays[7] = '{0, 1, 2, 3, 5, 14, 16};
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      model_mem[i] = v;
      bus_mem[i] = v;
    end
    repeat (3) tick();
    reset = 1'b0;
    chk("rst.stall", 32'(stall_out), 0);
    chk("rst.valid", 32'(valid_out), 0);
    chk("rst.req", 32'(bus.dmem_req), 0);
    chk("rst.we_be", {bus.dmem_we, bus.dmem_be}, 0);
    chk("rst.addr", 32'(bus.dmem_addr), 0);
    chk("rst.wdata", bus.dmem_wdata, 0);
    chk("rst.wb", {wb_en_out, wb_reg_out, fault_out}, 0);
    chk("rst.data", wb_data_out | iw_out | pc_out, 0);

    // ADD passes through with latency 1
    issue(OpAdd, 3'b000, 32'h42, 0, 1, 5, 0, 1);
    chk("add.valid", 32'(valid_out), 1);
    chk("add.data", wb_data_out, 32'h42);
    chk("add.req", 32'(bus.dmem_req), 0);

    // LB at 0x103 with delayed ack
    model_mem[32'h103 >> 2] = 32'h80FF_1234;
    bus_mem[32'h103 >> 2] = 32'h80FF_1234;
    issue(OpLoad, F3Byte, 32'h103, 0, 1, 7, 3, 1);
    stall_cnt = 0;
    while (stall_out && stall_cnt < 40) begin
      stall_cnt++;
      tick();
    end
    chk("lb.stall_ge3", 32'(stall_cnt >= 3), 1);
    wait_valid("lb.valid");
    chk("lb.data", wb_data_out, 32'hFFFF_FF80);

    // SH at 0x202
    issue(OpStore, F3Half, 32'h202, 32'hAAAA_BEEF, 1, 3, 1, 1);
    chk("sh.we", 32'(bus.dmem_we), 1);
    chk("sh.addr", 32'(bus.dmem_addr), 32'h80);
    chk("sh.be", 32'(bus.dmem_be), 32'hC);
    chk("sh.wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
    wait_valid("sh.valid");
    chk("sh.wb_en", 32'(wb_en_out), 0);

    // Misaligned LW
    issue(OpLoad, F3Word, 32'h101, 0, 1, 4, 0, 1);
    chk("mis.valid", 32'(valid_out), 1);
    chk("mis.fault", 32'(fault_out), 1);
    chk("mis.req", 32'(bus.dmem_req), 0);

    // Ack on the first request cycle gives latency 2
    issue(OpLoad, F3Word, 32'h200, 0, 1, 9, 0, 1);
    chk("lat2.valid0", 32'(valid_out), 0);
    chk("lat2.req", 32'(bus.dmem_req), 1);
    tick();
    chk("lat2.valid1", 32'(valid_out), 1);
    tick();

    // Timeout after TO request cycles, late ack ignored
    issue(OpLoad, F3Word, 32'h300, 0, 1, 6, TO + 1, 1);
    repeat (TO - 1) tick();
    chk("to.req_last", 32'(bus.dmem_req), 1);
    tick();
    chk("to.req_drop", 32'(bus.dmem_req), 0);
    chk("to.valid", 32'(valid_out), 1);
    chk("to.fault", 32'(fault_out), 2);
    repeat (25) tick();

    // Reset mid-access abandons the instruction
    issue(OpLoad, F3Word, 32'h304, 0, 1, 8, 10, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid.req", 32'(bus.dmem_req), 0);
    chk("rstmid.stall", 32'(stall_out), 0);
    chk("rstmid.valid", 32'(valid_out), 0);
    repeat (12) tick();
    issue(OpAdd, 3'b000, 32'h1234, 0, 1, 10, 0, 1);
    chk("rstmid.add", 32'(valid_out), 1);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      kind  = $urandom_range(0, 9);
      delay = delays[$urandom_range(0, 6)];
      alu   = $urandom_range(0, 4095);
      if ($urandom_range(0, 1) == 0) alu = alu & 32'hffc;
      f3 = 3'($urandom);
      if (kind < 3) op = ($urandom_range(0, 1) == 0) ? OpAdd : OpAddi;
      else if (kind < 8) op = OpLoad;
      else begin
        op = OpStore;
        if (kind == 8) f3 = 3'($urandom_range(0, 2));
      end
      if (kind < 3) alu = $urandom;
      issue(op, f3, alu, $urandom, 1'($urandom), 5'($urandom_range(0, 31)), delay, 1);
      if (delay > int'(TO)) repeat (25) tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    n = 0;
    while ((ret_q.size() != 0 || stall_out) && n < 300) begin
      tick();
      n++;
    end
    chk("drain.pending", 32'(ret_q.size()), 0);
    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
